pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
//  Generic inter-stage pipeline register with valid/ready handshake, replacing the fixed-field stage regs.
//  Carries an opaque control field and data field between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Control field is forced to all-zero (NOP) whenever the stage holds no valid beat.
//  Optional 2-entry skid buffer registers the ready path; a saturating back-pressure counter is included for perf.
// PARAMETERS
//  DATA_W      160  width of data payload (operands, imm, pc, pc+4)
//  CTRL_W      24   width of control payload (regWrite, MemRead, ALUop, ...); zero = no side effects
//  SKID        1    0: single entry, combinational in_ready; 1: 2-entry skid buffer, registered in_ready
//  ZERO_DATA   0    1: data field also cleared on reset/flush/drain; 0: data regs hold stale value
//  CNT_W       16   width of stall counter
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  flush      in   1       synchronous kill of every held beat and of the incoming beat
//  in_valid   in   1       upstream beat present
//  in_ready   out  1       stage can accept a beat this cycle
//  in_ctrl    in   CTRL_W  upstream control field
//  in_data    in   DATA_W  upstream data field
//  out_valid  out  1       head beat present
//  out_ready  in   1       downstream accepts head beat
//  out_ctrl   out  CTRL_W  head control field; 0 when out_valid=0
//  out_data   out  DATA_W  head data field
//  occupancy  out  2       beats held (0..1 for SKID=0, 0..2 for SKID=1)
//  stall_cnt  out  CNT_W   cycles with out_valid=1 && out_ready=0, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, skid entry empty.
//    in_ready=1 for SKID=1 (registered); for SKID=0 it follows its comb equation (=1 since empty).
//  - Transfers: accept = in_valid && in_ready; pop = out_valid && out_ready. Strict FIFO order, payload unmodified.
//  - Latency: accepted beat appears at out_* on the next rising edge when the stage is empty or pops this cycle.
//  - SKID=0: single register. in_ready = !out_valid || out_ready (comb). Full throughput, one beat/cycle.
//  - SKID=1 states: EMPTY(0), ONE(1, head only), TWO(2, head+skid). in_ready = (state!=TWO), from flop only.
//      EMPTY: accept -> ONE (head<=in).
//      ONE:   accept&pop -> ONE (head<=in); accept&!pop -> TWO (skid<=in); !accept&pop -> EMPTY.
//      TWO:   pop -> ONE (head<=skid); no accept possible.
//    Full throughput when out_ready=1 continuously; 1 beat absorbed when out_ready drops.
//  - flush=1: next state EMPTY regardless of accept/pop; incoming beat in that cycle is discarded (handshake
//    still completes if in_ready=1). Outputs in the flush cycle are unchanged; pop in that cycle still counts.
//    Flush overrides everything but reset.
//  - out_ctrl = head_ctrl when out_valid else 0 (bubble is a NOP by construction). With ZERO_DATA=1,
//    out_data=0 when out_valid=0; otherwise out_data holds last head value.
//  - stall_cnt: +1 each cycle out_valid && !out_ready; holds at 2^CNT_W-1; cleared only by reset, not flush.
//  - out_valid never deasserts without pop or flush; out_ctrl/out_data stable while out_valid && !out_ready.
//  - in_valid with in_ready=0 has no effect; upstream must hold the beat (not checked here).
//  - Reset asserted mid-transfer: all beats lost, outputs go to reset values immediately, no partial update.
// TESTING
//  1. Reset, SKID=1: stream ctrl=1..8, data=0x10..0x80, out_ready=1 -> out_valid 1 cycle later, 8 beats
//     back-to-back in order, in_ready stays 1, stall_cnt=0.
//  2. SKID=1: send A,B,C with out_ready=0 -> A at head, B in skid, occupancy=2, in_ready=0, C held upstream;
//     raise out_ready -> A,B,C delivered in order, stall_cnt = stall cycles.
//  3. Flush with occupancy=2 and in_valid=1 (beat D) -> next cycle out_valid=0, out_ctrl=0, occupancy=0,
//     D never appears; stall_cnt unchanged.
//  4. SKID=0: out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready tracks !out_valid||out_ready
//     same cycle, no beat lost or duplicated.
//  5. Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
//  6. Drop rst_n mid-stream at occupancy=2 -> out_valid=0, out_ctrl=0, occupancy=0 without clock edge;
//     with ZERO_DATA=1 out_data=0.

Source files
------------

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_hs
//  Purpose  : Generic inter-stage pipeline register with valid/ready
//             handshake. It carries an opaque control field and a data field,
//             and has an optional 2-entry skid buffer that keeps in_ready off
//             the combinational ready path. A saturating stall counter is
//             included.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
  parameter int DATA_W    = 160,
  parameter int CTRL_W    = 24,
  parameter int SKID      = 1,
  parameter int ZERO_DATA = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              w_valid;
  logic              w_in_ready;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [DATA_W-1:0] w_head_data;
  logic [1:0]        w_occ;
  logic              w_accept;
  logic              w_pop;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_accept = in_valid && w_in_ready;
  assign w_pop    = w_valid && out_ready;

  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [DATA_W-1:0] r_head_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    // Head/skid FSM; in_ready is a flop so upstream never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= S_EMPTY;
        r_in_ready  <= 1'b1;
        r_head_ctrl <= '0;
        r_head_data <= '0;
        r_skid_ctrl <= '0;
        r_skid_data <= '0;
      end else if (flush) begin
        // Everything held and the incoming beat are discarded.
        r_state    <= S_EMPTY;
        r_in_ready <= 1'b1;
        if (ZERO_DATA != 0) begin
          r_head_data <= '0;
          r_skid_data <= '0;
        end
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_accept) begin
              r_head_ctrl <= in_ctrl;
              r_head_data <= in_data;
              r_state     <= S_ONE;
            end
          end
          S_ONE: begin
            if (w_accept && w_pop) begin
              r_head_ctrl <= in_ctrl;
              r_head_data <= in_data;
            end else if (w_accept) begin
              // Downstream stalled: absorb the beat that was already in flight.
              r_skid_ctrl <= in_ctrl;
              r_skid_data <= in_data;
              r_state     <= S_TWO;
              r_in_ready  <= 1'b0;
            end else if (w_pop) begin
              r_state <= S_EMPTY;
              if (ZERO_DATA != 0) begin
                r_head_data <= '0;
              end
            end
          end
          S_TWO: begin
            if (w_pop) begin
              r_head_ctrl <= r_skid_ctrl;
              r_head_data <= r_skid_data;
              r_state     <= S_ONE;
              r_in_ready  <= 1'b1;
              if (ZERO_DATA != 0) begin
                r_skid_data <= '0;
              end
            end
          end
          default: begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end

    assign w_valid     = (r_state != S_EMPTY);
    assign w_in_ready  = r_in_ready;
    assign w_head_ctrl = r_head_ctrl;
    assign w_head_data = r_head_data;
    assign w_occ       = 2'(r_state);
  end else begin : g_single
    logic              r_valid;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [DATA_W-1:0] r_head_data;

    // Single holding register; refills in the same cycle the head pops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid     <= 1'b0;
        r_head_ctrl <= '0;
        r_head_data <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
        if (ZERO_DATA != 0) begin
          r_head_data <= '0;
        end
      end else if (w_accept) begin
        r_valid     <= 1'b1;
        r_head_ctrl <= in_ctrl;
        r_head_data <= in_data;
      end else if (w_pop) begin
        r_valid <= 1'b0;
        if (ZERO_DATA != 0) begin
          r_head_data <= '0;
        end
      end
    end

    assign w_valid     = r_valid;
    assign w_in_ready  = !r_valid || out_ready;
    assign w_head_ctrl = r_head_ctrl;
    assign w_head_data = r_head_data;
    assign w_occ       = {1'b0, r_valid};
  end

  // Saturating count of cycles the head beat is blocked; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  // A bubble is always presented as a NOP control word.
  assign out_valid = w_valid;
  assign in_ready  = w_in_ready;
  assign out_ctrl  = w_valid ? w_head_ctrl : '0;
  assign out_data  = ((ZERO_DATA != 0) && !w_valid) ? '0 : w_head_data;
  assign occupancy = w_occ;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_hs
//  Purpose  : Self-checking bench for pipe_stage_hs. One skid instance
//             (SKID=1, ZERO_DATA=1, CNT_W=4) and one single-register instance
//             (SKID=0) run side by side against queue-based reference models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

  localparam int c_dw = 32;
  localparam int c_cw = 8;

  typedef struct {
    logic [c_cw-1:0] c;
    logic [c_dw-1:0] d;
  } beat_t;

  logic clk;
  logic rst_n;

  // skid instance signals
  logic            s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [c_cw-1:0] s_in_ctrl, s_out_ctrl;
  logic [c_dw-1:0] s_in_data, s_out_data;
  logic [1:0]      s_occ;
  logic [3:0]      s_stall;

  // single-register instance signals
  logic            p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [c_cw-1:0] p_in_ctrl, p_out_ctrl;
  logic [c_dw-1:0] p_in_data, p_out_data;
  logic [1:0]      p_occ;
  logic [15:0]     p_stall;

  pipe_stage_hs #(
    .DATA_W(c_dw), .CTRL_W(c_cw), .SKID(1), .ZERO_DATA(1), .CNT_W(4)
  ) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .occupancy(s_occ), .stall_cnt(s_stall)
  );

  pipe_stage_hs #(
    .DATA_W(c_dw), .CTRL_W(c_cw), .SKID(0), .ZERO_DATA(0), .CNT_W(16)
  ) u_single (
    .clk(clk), .rst_n(rst_n), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_ctrl(p_in_ctrl), .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_ctrl(p_out_ctrl), .out_data(p_out_data),
    .occupancy(p_occ), .stall_cnt(p_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: contents of each stage, upstream pending beats, stall counts.
  beat_t mq_s[$];
  beat_t mq_p[$];
  beat_t src_s[$];
  beat_t src_p[$];
  int    exp_stall_s;
  int    exp_stall_p;
  bit    s_hold;
  bit    p_hold;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("s_out_valid", 64'(s_out_valid), 64'(mq_s.size() > 0));
    chk("s_out_ctrl",  64'(s_out_ctrl),  (mq_s.size() > 0) ? 64'(mq_s[0].c) : 64'd0);
    chk("s_out_data",  64'(s_out_data),  (mq_s.size() > 0) ? 64'(mq_s[0].d) : 64'd0);
    chk("s_in_ready",  64'(s_in_ready),  64'(mq_s.size() < 2));
    chk("s_occupancy", 64'(s_occ),       64'(mq_s.size()));
    chk("s_stall_cnt", 64'(s_stall),     64'(exp_stall_s));
    chk("p_out_valid", 64'(p_out_valid), 64'(mq_p.size() > 0));
    chk("p_out_ctrl",  64'(p_out_ctrl),  (mq_p.size() > 0) ? 64'(mq_p[0].c) : 64'd0);
    if (mq_p.size() > 0) chk("p_out_data", 64'(p_out_data), 64'(mq_p[0].d));
    chk("p_in_ready",  64'(p_in_ready),  64'((mq_p.size() == 0) || p_out_ready));
    chk("p_occupancy", 64'(p_occ),       64'(mq_p.size()));
    chk("p_stall_cnt", 64'(p_stall),     64'(exp_stall_p));
  endtask

  task automatic drive();
    s_in_valid = (src_s.size() > 0) && !s_hold;
    s_in_ctrl  = (src_s.size() > 0) ? src_s[0].c : '0;
    s_in_data  = (src_s.size() > 0) ? src_s[0].d : '0;
    p_in_valid = (src_p.size() > 0) && !p_hold;
    p_in_ctrl  = (src_p.size() > 0) ? src_p[0].c : '0;
    p_in_data  = (src_p.size() > 0) ? src_p[0].d : '0;
  endtask

  // One clock: called at a falling edge with control inputs already set.
  task automatic cycle();
    bit acc_s, pop_s, acc_p, pop_p;
    drive();
    #1;
    check_all();
    acc_s = s_in_valid && (mq_s.size() < 2);
    pop_s = (mq_s.size() > 0) && s_out_ready;
    acc_p = p_in_valid && ((mq_p.size() == 0) || p_out_ready);
    pop_p = (mq_p.size() > 0) && p_out_ready;
    @(posedge clk);
    #1;
    if ((mq_s.size() > 0) && !s_out_ready && (exp_stall_s < 15)) exp_stall_s++;
    if ((mq_p.size() > 0) && !p_out_ready && (exp_stall_p < 65535)) exp_stall_p++;
    if (s_flush) begin
      mq_s.delete();
      src_s.delete();
    end else begin
      if (pop_s) void'(mq_s.pop_front());
      if (acc_s) mq_s.push_back(src_s.pop_front());
    end
    if (p_flush) begin
      mq_p.delete();
      src_p.delete();
    end else begin
      if (pop_p) void'(mq_p.pop_front());
      if (acc_p) mq_p.push_back(src_p.pop_front());
    end
    @(negedge clk);
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    b.c = c_cw'($urandom);
    b.d = $urandom;
    return b;
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    exp_stall_s = 0; exp_stall_p = 0;
    s_hold = 0; p_hold = 0;
    rst_n = 1'b0;
    s_flush = 0; p_flush = 0; s_out_ready = 1; p_out_ready = 1;
    drive();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: back-to-back stream ctrl=1..8, data=0x10..0x80 with out_ready=1
    for (int i = 1; i <= 8; i++) begin
      src_s.push_back('{c: c_cw'(i), d: c_dw'(i * 16)});
      src_p.push_back('{c: c_cw'(i), d: c_dw'(i * 16)});
    end
    repeat (11) cycle();
    chk("t1_stall_zero", 64'(s_stall), 64'd0);

    // 2: A,B,C into a stalled skid stage, then release
    s_out_ready = 0;
    src_s.push_back('{c: 8'hA1, d: 32'hAAAA_0001});
    src_s.push_back('{c: 8'hB2, d: 32'hBBBB_0002});
    src_s.push_back('{c: 8'hC3, d: 32'hCCCC_0003});
    repeat (4) cycle();
    chk("t2_occ_two", 64'(s_occ), 64'd2);
    chk("t2_in_ready_low", 64'(s_in_ready), 64'd0);
    s_out_ready = 1;
    repeat (5) cycle();

    // 3: flush at occupancy 2 with beat D pending
    s_out_ready = 0;
    src_s.push_back(rnd_beat());
    src_s.push_back(rnd_beat());
    src_s.push_back('{c: 8'hD4, d: 32'hDDDD_0004});
    repeat (3) cycle();
    s_out_ready = 1;
    s_flush = 1;
    cycle();
    s_flush = 0;
    repeat (3) cycle();
    chk("t3_occ_zero", 64'(s_occ), 64'd0);

    // 5: stall-counter saturation on the 4-bit counter
    s_out_ready = 0;
    src_s.push_back(rnd_beat());
    repeat (22) cycle();
    chk("t5_saturated", 64'(s_stall), 64'd15);
    s_out_ready = 1;
    repeat (3) cycle();

    // 4: single-register stage with out_ready toggling under continuous input
    for (int i = 0; i < 10; i++) src_p.push_back(rnd_beat());
    for (int i = 0; i < 16; i++) begin
      p_out_ready = (i % 2 == 0);
      cycle();
    end
    p_out_ready = 1;
    repeat (4) cycle();

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      if (src_s.size() < 3) src_s.push_back(rnd_beat());
      if (src_p.size() < 3) src_p.push_back(rnd_beat());
      s_out_ready = ($urandom_range(0, 9) < 7);
      p_out_ready = ($urandom_range(0, 9) < 7);
      s_hold      = ($urandom_range(0, 9) < 2);
      p_hold      = ($urandom_range(0, 9) < 2);
      s_flush     = ($urandom_range(0, 39) == 0);
      p_flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    s_hold = 0; p_hold = 0; s_flush = 0; p_flush = 0;

    // 6: asynchronous reset mid-stream at occupancy 2
    s_out_ready = 0; p_out_ready = 0;
    src_s.delete(); src_p.delete();
    for (int i = 0; i < 3; i++) begin
      src_s.push_back(rnd_beat());
      src_p.push_back(rnd_beat());
    end
    repeat (3) cycle();
    chk("t6_pre_occ", 64'(s_occ), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    mq_s.delete(); mq_p.delete(); src_s.delete(); src_p.delete();
    exp_stall_s = 0; exp_stall_p = 0;
    drive();
    check_all();
    chk("t6_data_zero", 64'(s_out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_out_ready = 1; p_out_ready = 1;
    src_s.push_back(rnd_beat());
    src_p.push_back(rnd_beat());
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
